// File: rtl/z_core_pkg.sv
// Shared RV32I decode constants and ALU operation codes for the z_core pipeline.
package z_core_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_SLL  = 4'd2,  ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,  ALU_XOR  = 4'd5,  ALU_SRL  = 4'd6,  ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,  ALU_AND  = 4'd9,  ALU_BEQ  = 4'd10, ALU_BNE  = 4'd11,
    ALU_BLT  = 4'd12, ALU_BGE  = 4'd13, ALU_BLTU = 4'd14, ALU_BGEU = 4'd15
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    alu_op_e     op;
    logic        is_branch;
    logic        illegal;
  } issue_pkt_t;

  // alt selects SUB (funct3 000) or SRA (funct3 101); ignored elsewhere.
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD_SUB: arith_op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     arith_op = ALU_SLL;
      F3_SLT:     arith_op = ALU_SLT;
      F3_SLTU:    arith_op = ALU_SLTU;
      F3_XOR:     arith_op = ALU_XOR;
      F3_SRL_SRA: arith_op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      arith_op = ALU_OR;
      default:    arith_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/z_core_imm_gen.sv
// RV32I immediate extraction; opcode bits are not needed so only inst[31:7] enters.
module z_core_imm_gen (
  input  logic [31:7] inst,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j
);

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

endmodule

// File: rtl/z_core_alu_issue.sv
// ALU issue stage: combinational RV32I decode feeding a two-entry skid buffer.
module z_core_alu_issue
  import z_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_inst_type,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rd,
  output logic [31:0] out_imm,
  output logic        out_is_branch,
  output logic        out_illegal
);

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        bad;
  issue_pkt_t  dec, main_q, skid_q;
  logic        skid_valid;
  logic        accept, main_free;

  z_core_imm_gen u_imm_gen (
    .inst  (in_inst[31:7]),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];

  always_comb begin
    dec     = '0;
    dec.pc  = in_pc;
    dec.op  = ALU_ADD;
    bad     = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.in1 = in_rs1_data;
        dec.in2 = in_rs2_data;
        dec.rd  = in_inst[11:7];
        dec.op  = arith_op(f3, in_inst[30]);
      end
      OPC_OP_IMM: begin
        dec.in1 = in_rs1_data;
        // Shift immediates carry funct7 in imm[11:5]; only the shamt is an operand.
        dec.in2 = (f3 == F3_SLL || f3 == F3_SRL_SRA) ? {27'd0, in_inst[24:20]} : imm_i;
        dec.imm = imm_i;
        dec.rd  = in_inst[11:7];
        dec.op  = arith_op(f3, (f3 == F3_SRL_SRA) && in_inst[30]);
      end
      OPC_LUI: begin
        dec.in2 = imm_u;
        dec.imm = imm_u;
        dec.rd  = in_inst[11:7];
      end
      OPC_AUIPC: begin
        dec.in1 = in_pc;
        dec.in2 = imm_u;
        dec.imm = imm_u;
        dec.rd  = in_inst[11:7];
      end
      OPC_LOAD: begin
        dec.in1 = in_rs1_data;
        dec.in2 = imm_i;
        dec.imm = imm_i;
        dec.rd  = in_inst[11:7];
      end
      OPC_STORE: begin
        dec.in1 = in_rs1_data;
        dec.in2 = imm_s;
        dec.imm = imm_s;
      end
      OPC_JAL, OPC_JALR: begin
        dec.in1 = in_pc;
        dec.in2 = 32'd4;
        dec.imm = (opcode == OPC_JAL) ? imm_j : imm_i;
        dec.rd  = in_inst[11:7];
      end
      OPC_BRANCH: begin
        dec.in1       = in_rs1_data;
        dec.in2       = in_rs2_data;
        dec.imm       = imm_b;
        dec.is_branch = 1'b1;
        case (f3)
          F3_BEQ:  dec.op = ALU_BEQ;
          F3_BNE:  dec.op = ALU_BNE;
          F3_BLT:  dec.op = ALU_BLT;
          F3_BGE:  dec.op = ALU_BGE;
          F3_BLTU: dec.op = ALU_BLTU;
          F3_BGEU: dec.op = ALU_BGEU;
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.illegal = 1'b1;
    end
  end

  assign accept    = in_valid && in_ready && !flush;
  assign main_free = !out_valid || out_ready;

  // in_ready tracks the next skid state so out_ready never reaches it combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (main_free) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= accept;
        in_ready   <= !accept;
        if (accept) skid_q <= dec;
      end else begin
        out_valid <= accept;
        in_ready  <= 1'b1;
        if (accept) main_q <= dec;
      end
    end else begin
      if (accept) begin
        skid_q     <= dec;
        skid_valid <= 1'b1;
      end
      in_ready <= !(skid_valid || accept);
    end
  end

  assign alu_in1       = main_q.in1;
  assign alu_in2       = main_q.in2;
  assign alu_inst_type = main_q.op;
  assign out_pc        = main_q.pc;
  assign out_rd        = main_q.rd;
  assign out_imm       = main_q.imm;
  assign out_is_branch = main_q.is_branch;
  assign out_illegal   = main_q.illegal;

endmodule

// File: doc/z_core_alu_issue.md
Z_CORE_ALU_ISSUE -- requirements
Module: z_core_alu_issue

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-002 The module SHALL have the port rst, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-003 The module SHALL have the port in_valid, input, 1 bit: a decoded-stage instruction is presented.
REQ-004 The module SHALL have the port in_ready, output, 1 bit: the stage accepts the presented instruction this cycle.
REQ-005 The module SHALL have the port in_inst, input, 32 bits: the RV32I instruction word.
REQ-006 The module SHALL have the port in_pc, input, 32 bits: the instruction address.
REQ-007 The module SHALL have the ports in_rs1_data and in_rs2_data, input, 32 bits each: the register-file read data.
REQ-008 The module SHALL have the port flush, input, 1 bit: discard all held and presented instructions.
REQ-009 The module SHALL have the port out_valid, output, 1 bit: the execute payload is valid.
REQ-010 The module SHALL have the port out_ready, input, 1 bit: the ALU/execute stage consumes the payload this cycle.
REQ-011 The module SHALL have the ports alu_in1 and alu_in2, output, 32 bits each: the ALU operands.
REQ-012 The module SHALL have the port alu_inst_type, output, 4 bits: the ALU operation code.
REQ-013 The module SHALL have the following side-band outputs: out_pc (32 bits), out_rd (5 bits), out_imm (32 bits), out_is_branch (1 bit), out_illegal (1 bit).

Function
REQ-014 alu_inst_type SHALL use this encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
REQ-015 OP (0110011) SHALL drive rs1/rs2 as operands; the type SHALL be selected by funct3; funct7[5] SHALL select SUB for funct3=000 and SRA for funct3=101.
REQ-016 OP-IMM (0010011) SHALL drive rs1/imm_I as operands; funct3=101 with inst[30]=1 SHALL select SRA; funct3=000 SHALL never select SUB.
REQ-017 LUI SHALL drive 0/imm_U with ADD.
REQ-018 AUIPC SHALL drive pc/imm_U with ADD.
REQ-019 LOAD SHALL drive rs1/imm_I with ADD, and STORE SHALL drive rs1/imm_S with ADD.
REQ-020 JAL and JALR SHALL drive pc/32'd4 with ADD, and out_imm SHALL be imm_J or imm_I respectively.
REQ-021 BRANCH SHALL drive rs1/rs2, SHALL map funct3 000,001,100,101,110,111 to 10..15, SHALL drive out_imm=imm_B, and SHALL assert out_is_branch=1.
REQ-022 A BRANCH with funct3 010/011, or any unlisted opcode, SHALL set out_illegal=1 with type ADD and zero operands; the instruction SHALL still flow through the handshake.
REQ-023 out_rd SHALL be inst[11:7] for register-writing classes, and SHALL be 0 for BRANCH, STORE and illegal instructions.
REQ-024 The stage SHALL be a two-entry skid buffer consisting of a main output register and a skid register.
REQ-025 A transfer SHALL occur on in_valid & in_ready, and out_valid & out_ready.
REQ-026 Latency SHALL be one cycle: an accepted instruction SHALL appear on the outputs the next cycle when the main register is empty or being drained.
REQ-027 in_ready SHALL be a registered signal equal to !skid_valid, with no combinational path from out_ready.
REQ-028 Accept while the main register is full and not draining SHALL load the skid register; when the main register drains, the skid contents SHALL move to main in the same edge.
REQ-029 The payload SHALL be held stable while out_valid & !out_ready, with no change permitted.
REQ-030 Instructions SHALL leave in the order they were accepted, with no loss or duplication.
REQ-031 flush SHALL clear out_valid and skid_valid at the next edge.
REQ-032 An instruction presented in the same cycle as flush SHALL be dropped.
REQ-033 in_ready SHALL be 1 the cycle after flush.
REQ-034 flush SHALL take priority over simultaneous accept and drain.

Reset
REQ-035 Asserting rst SHALL immediately force out_valid=0, skid_valid=0 and in_ready=0.
REQ-036 After rst deasserts, in_ready SHALL become 1 on the first edge.
REQ-037 After rst deasserts, payload registers (alu_in1, alu_in2, out_pc, out_imm) SHALL read 0, alu_inst_type SHALL read 0 (ADD), out_rd SHALL read 0, and out_is_branch and out_illegal SHALL read 0.
REQ-038 Reset mid-stall SHALL discard both entries with no residual output.

Structure
REQ-039 A shared package z_core_pkg SHALL hold the ALU operation constants (0..15), the RV32I opcode constants and the funct3 constants; the ALU and this block SHALL share them.
REQ-040 Immediate extraction SHALL be placed in the combinational sub-module z_core_imm_gen, which produces imm_I, imm_S, imm_B, imm_U and imm_J from inst.
REQ-041 Decode SHALL be combinational ahead of the skid registers, and no decode logic SHALL follow the registers.

Verification
REQ-042 With out_ready=1, present ADD x3,x1,x2 with rs1=2 and rs2=3 -> the next cycle SHALL show out_valid=1, alu_in1=2, alu_in2=3, type=0 and rd=3.
REQ-043 Present SUB (funct7=0100000) with rs1=5 and rs2=3 -> type SHALL be 1; SRAI with shamt 4 -> type SHALL be 7 and alu_in2=4; ADDI -12 -> alu_in2=32'hFFFFFFF4 and type 0.
REQ-044 Present BGEU at pc=0x100 with offset -8 -> type SHALL be 15, out_is_branch=1, out_imm=32'hFFFFFFF8 and rd=0; AUIPC 0x12345 at pc=0x40 -> alu_in1=0x40, alu_in2=0x12345000 and type 0.
REQ-045 Stream 6 instructions with out_ready low for 3 cycles mid-stream -> in_ready SHALL fall one cycle after the skid fills, all 6 instructions SHALL exit in order with no duplicates, and the payload SHALL be stable during the stall.
REQ-046 Hold two entries, then assert flush together with in_valid -> out_valid SHALL be 0 the next cycle, the presented instruction SHALL never appear, and in_ready SHALL be 1.
REQ-047 Opcode 0000000, and separately BRANCH with funct3=010 -> out_illegal SHALL be 1, type 0 and operands 0; asynchronous rst while stalled -> out_valid SHALL be 0 immediately.
